// File: rtl/ir_nec_tx_if.sv
// Handshake bundle between a key-code source and the NEC IR transmitter.
interface ir_nec_tx_if;
    logic       send;
    logic [7:0] hex_data;
    logic       busy;
    logic       done;
    logic       ir_out;

    modport master (output send, output hex_data, input busy, input done, input ir_out);
    modport slave  (input send, input hex_data, output busy, output done, output ir_out);
endinterface

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: one key code per send edge, carrier-modulated frame on ir_out.
// Optional IR_REPEAT_EN: a held send emits NEC repeat frames after each 108 ms period.
module ir_nec_tx #(
    parameter int          UNIT_CYC     = 28125,
    parameter int          CARRIER_HALF = 658,
    parameter logic [15:0] CUSTOM_CODE  = 16'h00FF
) (
    input  logic       CLK,
    input  logic       RST_N,
    ir_nec_tx_if.slave bus
);
    localparam int UW = $clog2(UNIT_CYC);
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [UW-1:0] UNIT_LAST   = UW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] CAR_LAST    = CW'(CARRIER_HALF - 1);
    localparam logic [7:0]    FRAME_UNITS = 8'd192;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LEAD_MARK  = 4'd1;
    localparam logic [3:0] S_LEAD_SPACE = 4'd2;
    localparam logic [3:0] S_BIT_MARK   = 4'd3;
    localparam logic [3:0] S_BIT_SPACE  = 4'd4;
    localparam logic [3:0] S_STOP_MARK  = 4'd5;
    localparam logic [3:0] S_GAP        = 4'd6;
`ifdef IR_REPEAT_EN
    localparam logic [3:0] S_REP_MARK   = 4'd7;
    localparam logic [3:0] S_REP_SPACE  = 4'd8;
`endif

    // The 32 transmitted bits, sent LSB first: custom low, custom high, code, ~code.
    function automatic logic frame_bit(input logic [7:0] code, input logic [4:0] idx);
        logic [31:0] word;
        word = {~code, code, CUSTOM_CODE};
        return word[idx];
    endfunction

    function automatic logic is_mark(input logic [3:0] st);
        logic m;
        case (st)
            S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: m = 1'b1;
`ifdef IR_REPEAT_EN
            S_REP_MARK:                           m = 1'b1;
`endif
            default:                              m = 1'b0;
        endcase
        return m;
    endfunction

    logic [3:0]    state_r;
    logic [3:0]    state_nxt_s;
    logic          send_d_r;
    logic [7:0]    code_r;
    logic [UW-1:0] unit_cnt_r;
    logic [4:0]    su_cnt_r;
    logic [7:0]    frame_cnt_r;
    logic [4:0]    bit_idx_r;
    logic [CW-1:0] car_cnt_r;
    logic          ir_r;
    logic          busy_r;
    logic          done_r;

    logic          accept_s;
    logic          unit_end_s;
    logic          last_unit_s;
    logic          gap_end_s;
    logic [4:0]    len_s;
    logic          mark_nxt_s;
    logic          mark_enter_s;

    assign accept_s     = bus.send && !send_d_r && !busy_r;
    assign unit_end_s   = (state_r != S_IDLE) && (unit_cnt_r == UNIT_LAST);
    assign last_unit_s  = unit_end_s && (su_cnt_r == (len_s - 5'd1));
    assign gap_end_s    = unit_end_s && (frame_cnt_r == (FRAME_UNITS - 8'd1));
    assign mark_nxt_s   = is_mark(state_nxt_s);
    assign mark_enter_s = mark_nxt_s && (state_nxt_s != state_r);

    // Length in units of the current state
    always_comb begin
        len_s = 5'd1;
        case (state_r)
            S_LEAD_MARK:  len_s = 5'd16;
            S_LEAD_SPACE: len_s = 5'd8;
            S_BIT_SPACE:  len_s = frame_bit(code_r, bit_idx_r) ? 5'd3 : 5'd1;
`ifdef IR_REPEAT_EN
            S_REP_MARK:   len_s = 5'd16;
            S_REP_SPACE:  len_s = 5'd4;
`endif
            default:      len_s = 5'd1;
        endcase
    end

    // Next-state logic; every transition lands on the last cycle of a state's final unit
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:       if (accept_s)    state_nxt_s = S_LEAD_MARK;  else state_nxt_s = S_IDLE;
            S_LEAD_MARK:  if (last_unit_s) state_nxt_s = S_LEAD_SPACE; else state_nxt_s = state_r;
            S_LEAD_SPACE: if (last_unit_s) state_nxt_s = S_BIT_MARK;   else state_nxt_s = state_r;
            S_BIT_MARK:   if (last_unit_s) state_nxt_s = S_BIT_SPACE;  else state_nxt_s = state_r;
            S_BIT_SPACE: begin
                if (last_unit_s) begin
                    if (bit_idx_r == 5'd31) state_nxt_s = S_STOP_MARK;
                    else                    state_nxt_s = S_BIT_MARK;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_STOP_MARK:  if (last_unit_s) state_nxt_s = S_GAP;        else state_nxt_s = state_r;
            S_GAP: begin
                if (gap_end_s) begin
`ifdef IR_REPEAT_EN
                    if (bus.send) state_nxt_s = S_REP_MARK;
                    else          state_nxt_s = S_IDLE;
`else
                    state_nxt_s = S_IDLE;
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
`ifdef IR_REPEAT_EN
            S_REP_MARK:   if (last_unit_s) state_nxt_s = S_REP_SPACE;  else state_nxt_s = state_r;
            S_REP_SPACE:  if (last_unit_s) state_nxt_s = S_STOP_MARK;  else state_nxt_s = state_r;
`endif
            default:      state_nxt_s = S_IDLE;
        endcase
    end

    // State, request edge detect, latched key and unit/frame/bit counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= S_IDLE;
            send_d_r    <= 1'b0;
            code_r      <= 8'd0;
            unit_cnt_r  <= '0;
            su_cnt_r    <= 5'd0;
            frame_cnt_r <= 8'd0;
            bit_idx_r   <= 5'd0;
        end else begin
            state_r  <= state_nxt_s;
            send_d_r <= bus.send;
            if (accept_s) code_r <= bus.hex_data;

            if (state_r == S_IDLE || unit_end_s) unit_cnt_r <= '0;
            else                                 unit_cnt_r <= unit_cnt_r + UW'(1);

            if (state_nxt_s != state_r) su_cnt_r <= 5'd0;
            else if (unit_end_s)        su_cnt_r <= su_cnt_r + 5'd1;

            // Restart frame timing on idle and on every repeat-frame start
            if (state_r == S_IDLE || gap_end_s)             frame_cnt_r <= 8'd0;
            else if (unit_end_s && frame_cnt_r != FRAME_UNITS) frame_cnt_r <= frame_cnt_r + 8'd1;

            if (state_r == S_IDLE)                            bit_idx_r <= 5'd0;
            else if (state_r == S_BIT_SPACE && last_unit_s)  bit_idx_r <= bit_idx_r + 5'd1;
        end
    end

    // Registered outputs; carrier phase restarts high at the first cycle of each mark
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            car_cnt_r <= '0;
            ir_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (mark_enter_s) begin
                car_cnt_r <= '0;
                ir_r      <= 1'b1;
            end else if (mark_nxt_s) begin
                if (car_cnt_r == CAR_LAST) begin
                    car_cnt_r <= '0;
                    ir_r      <= ~ir_r;
                end else begin
                    car_cnt_r <= car_cnt_r + CW'(1);
                end
            end else begin
                car_cnt_r <= '0;
                ir_r      <= 1'b0;
            end
            busy_r <= (state_nxt_s != S_IDLE);
            done_r <= (state_r == S_STOP_MARK) && (state_nxt_s == S_GAP);
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.ir_out = ir_r;
endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: a segment-level NEC model predicts each 192-unit window.
module tb_ir_nec_tx;
    localparam int          U  = 4;
    localparam int          CH = 1;
    localparam logic [15:0] CC = 16'h00FF;
    localparam int          FC = 192 * U;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ir_nec_tx_if bus ();

    ir_nec_tx #(.UNIT_CYC(U), .CARRIER_HALF(CH), .CUSTOM_CODE(CC)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FC-1:0] ir;
        int            done_at;
        bit            cont;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    bit   mon_active = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Frame as alternating mark/space unit counts, expanded into cycles with the carrier
    function automatic exp_t model(input logic [7:0] key, input bit rep, input bit cont);
        exp_t        e;
        int          segs[$];
        int          pos;
        logic [31:0] w;
        e.ir   = '0;
        e.cont = cont;
        if (rep) begin
            segs = '{16, 4, 1};
        end else begin
            segs = '{16, 8};
            w = {~key, key, CC};
            for (int i = 0; i < 32; i++) begin
                segs.push_back(1);
                segs.push_back(w[i] ? 3 : 1);
            end
            segs.push_back(1);
        end
        pos = 0;
        foreach (segs[s]) begin
            for (int k = 0; k < segs[s] * U; k++) begin
                if (s % 2 == 0) e.ir[pos] = 1'(((k / CH) % 2) == 0);
                pos++;
            end
        end
        e.done_at = pos;
        return e;
    endfunction

    // Monitor: each 192-unit busy window is captured and compared with the next expectation
    initial begin : monitor
        exp_t          e;
        logic [FC-1:0] got;
        int            done_cnt, done_pos, busy_lo, mism;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                mon_active = 1'b1;
                do begin
                    got = '0; done_cnt = 0; done_pos = -1; busy_lo = 0;
                    for (int i = 0; i < FC; i++) begin
                        if (i > 0) @(negedge clk);
                        got[i] = bus.ir_out;
                        if (bus.done) begin done_cnt++; done_pos = i; end
                        if (!bus.busy) busy_lo++;
                    end
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        mism = -1;
                        for (int i = FC - 1; i >= 0; i--) if (got[i] !== e.ir[i]) mism = i;
                        chk("ir_trace_first_bad_cycle", mism, -1);
                        chk("done_pulse_count", done_cnt, 1);
                        chk("done_cycle", done_pos, e.done_at);
                        chk("busy_low_inside_window", busy_lo, 0);
                        chk("busy_after_window", bus.busy, e.cont);
                    end
                end while (bus.busy);
                mon_active = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] key, input int hold, input int second_at);
        int t;
        int reps;
        t = 0;
        while (bus.busy && t < 4000) begin @(negedge clk); t++; end
        chk("wait_idle_timeout", (t >= 4000), 0);
        bus.hex_data = key;
        bus.send     = 1'b1;
        reps = 0;
`ifdef IR_REPEAT_EN
        while (FC * (reps + 1) <= hold - 1) reps++;
`endif
        exp_q.push_back(model(key, 1'b0, reps > 0));
        for (int r = 1; r <= reps; r++) exp_q.push_back(model(8'h00, 1'b1, r < reps));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) bus.hex_data = 8'($urandom);
        end
        bus.send = 1'b0;
        if (second_at >= 0) begin
            for (int i = hold - 1; i < second_at; i++) @(negedge clk);
            bus.send = 1'b1;
            repeat (5) @(negedge clk);
            bus.send = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        int act;
        int t;
        bus.send     = 1'b0;
        bus.hex_data = 8'h00;
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_ir_out", bus.ir_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.ir_out || bus.done) act++;
        end
        chk("idle_after_reset", act, 0);

        // Abort a frame in its leader mark with an asynchronous reset
        bus.hex_data = 8'h5A;
        bus.send     = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.busy && t < 10);
        chk("abort_busy_rise", bus.busy, 1);
        repeat (10) @(negedge clk);
        chk("abort_carrier_high", bus.ir_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ir_out", bus.ir_out, 0);
        chk("abort_busy", bus.busy, 0);
        bus.send = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.busy || bus.ir_out || bus.done) act++;
        end
        chk("no_resume_after_abort", act, 0);

        mon_en = 1'b1;
        send_frame(8'h05, 5, -1);
        send_frame(8'h12, 5, -1);
        send_frame(8'hA7, 5, 300);
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_frame(8'($urandom), $urandom_range(1, 700), -1);
        end
        send_frame(8'h3C, 2000, -1);

        t = 0;
        while ((bus.busy || mon_active) && t < 4000) begin @(negedge clk); t++; end
        chk("drain_timeout", (t >= 4000), 0);
        repeat (20) @(negedge clk);
        chk("leftover_expected_frames", exp_q.size(), 0);
        chk("final_busy", bus.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
- NEC-protocol infrared transmitter: the sending end of the IR remote link whose decoded key codes (hex_data / data_ready) drive the calculator.
- Accepts one 8-bit key code per request and emits a complete NEC frame as a carrier-modulated output for an IR LED driver.
- Used for loopback testing of the receive path and as a board-to-board remote.

Parameters:
- UNIT_CYC, 28125: CLK cycles per NEC unit (562.5 us at 50 MHz); must be >= 2.
- CARRIER_HALF, 658: CLK cycles per carrier half-period (about 38 kHz at 50 MHz); must be >= 1.
- CUSTOM_CODE, 16'h00FF: 16-bit NEC custom/address code.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- send  in  1  transmit request, level signal; a frame starts on its rising edge.
- hex_data  in  8  key code, sampled in the cycle the request is accepted.
- busy  out  1  high while a frame or its trailing gap is in progress.
- done  out  1  one-cycle pulse at the end of the stop mark.
- ir_out  out  1  modulated IR output, registered.

Behaviour:
- Reset: asynchronous, active-low. busy=0, done=0, ir_out=0, state=IDLE, send_d=0, all counters 0. Asserting RST_N mid-frame aborts the frame immediately; nothing is resumed after release.
- Accept rule: send && !send_d && !busy, where send_d is send registered on CLK. On accept, latch hex_data into code_r; busy=1 and LEAD_MARK start on the next cycle. Rising edges while busy=1 are dropped, not queued.
- Unit timing: a unit counter counts 0..UNIT_CYC-1. A frame counter counts units from frame start, saturating at 192.
- Frame units: LEAD_MARK 16, LEAD_SPACE 8, then 32 bits, then STOP_MARK 1, then GAP until the frame counter reaches 192 (108 ms frame period).
- Bit order: LSB first, in the sequence CUSTOM_CODE[7:0], CUSTOM_CODE[15:8], code_r, ~code_r.
- Bit encoding: BIT_MARK 1 unit, then BIT_SPACE of 1 unit for a 0 or 3 units for a 1. A 5-bit index counts 0..31.
- States: IDLE -> LEAD_MARK -> LEAD_SPACE -> BIT_MARK <-> BIT_SPACE (32 times) -> STOP_MARK -> GAP -> IDLE.
- Transition timing: each transition happens on the last cycle of the state's final unit.
- done: pulses for one cycle on the first cycle of GAP.
- busy: falls on entry to IDLE, i.e. exactly 192*UNIT_CYC cycles after it rose.
- Carrier: in any mark state, ir_out toggles every CARRIER_HALF cycles. Phase restarts high on the first cycle of every mark.
- Non-mark states: ir_out=0 in every space, GAP and IDLE.
- With CUSTOM_CODE=16'h00FF, every frame contains 16 ones and 16 zeros. The stop mark therefore ends at unit 121 regardless of code.
- Since ~code_r is computed from the latched value, hex_data may change freely after accept.

Optional Feature:
- Macro: IR_REPEAT_EN.
- Defined: on each GAP exit, if send is still high, the block sends an NEC repeat frame instead of entering IDLE. Repeat frame: REP_MARK 16 units, REP_SPACE 4 units, STOP_MARK 1 unit, GAP to 192 units. done pulses after each stop mark; busy stays 1 throughout.
- Repeats stop at the first GAP exit that sees send=0.
- Not defined: no repeat states exist; a held send produces one frame only, and a new frame needs send to go low then high again.

Test Plan (UNIT_CYC=4, CARRIER_HALF=1, CUSTOM_CODE=16'h00FF):
- Reset: pulse RST_N low during LEAD_MARK -> ir_out=0, busy=0 with no clock edge. Reset release with send=0 -> no activity.
- Key 0x05: rising edge of send -> busy rises 1 cycle later. Envelope is 64 cycles mark, 32 space, then bits FF,00,05,FA LSB first. done at cycle 484 after busy rises; busy high for exactly 768 cycles.
- Carrier: during any mark, ir_out=1,0,1,0... starting high. During spaces ir_out=0 for every cycle.
- Key 0x12: data-byte spaces measure 4,12,4,4,12,4,4,4 cycles. Complement-byte spaces measure 12,4,12,12,4,12,12,12 cycles.
- Handshake: second send edge at cycle 300 of a frame -> ignored, one frame only. A send edge 1 cycle after busy falls -> new frame starts.
- IR_REPEAT_EN: hold send high for 2000 cycles -> one full frame plus repeat frames (64 mark, 16 space, 4 mark) starting at cycles 768 and 1536; busy falls at 2304. Without the macro, one frame only.
